// File: rtl/mem_arb_pkg.sv
// Shared encodings for the RAM port arbiter: owner codes and the transaction FSM states.
package mem_arb_pkg;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_MEM  = 2'd2;
   localparam logic [1:0] OWN_LD   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority request picker: the loader beats the MEM stage, which beats instruction fetch.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       i_if_req,
   input  logic       i_mem_req,
   input  logic       i_ld_req,
   output logic [1:0] o_owner,
   output logic       o_valid
);

   // Highest-priority active request wins.
   always_comb begin
      o_owner = OWN_NONE;
      o_valid = 1'b0;
      if (i_ld_req) begin
         o_owner = OWN_LD;
         o_valid = 1'b1;
      end else if (i_mem_req) begin
         o_owner = OWN_MEM;
         o_valid = 1'b1;
      end else if (i_if_req) begin
         o_owner = OWN_IF;
         o_valid = 1'b1;
      end else begin
         o_owner = OWN_NONE;
         o_valid = 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between fetch, the MEM stage and the boot loader,
// with a req/ack handshake per requester so the sequencer can stall on memory.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RAM_ADDR_W = 14,
   parameter int RAM_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_ack,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W-1:0]     mem_rdata,
   output logic                  mem_ack,
   input  logic                  ld_req,
   input  logic [ADDR_W-1:0]     ld_addr,
   input  logic [DATA_W-1:0]     ld_wdata,
   output logic                  ld_ack,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   output logic                  ram_we,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic [1:0]            owner,
   output logic                  busy
);

   localparam logic [3:0] LP_CNT_INIT = 4'(RAM_LAT - 1);

   arb_state_t            r_state;
   logic [1:0]            r_owner;
   logic                  r_we;
   logic [3:0]            r_cnt;
   logic [RAM_ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0]     r_ram_wdata;
   logic                  r_ram_we;
   logic [DATA_W-1:0]     r_if_rdata;
   logic [DATA_W-1:0]     r_mem_rdata;
   logic                  r_if_ack;
   logic                  r_mem_ack;
   logic                  r_ld_ack;

   logic [1:0]            w_pick_owner;
   logic                  w_pick_valid;
   logic [RAM_ADDR_W-1:0] w_sel_idx;
   logic [DATA_W-1:0]     w_sel_wdata;
   logic                  w_sel_we;
   logic                  w_capture;
   logic                  w_enter_done;
   logic                  w_unused;

   mem_arb_pick u_pick (
      .i_if_req  (if_req),
      .i_mem_req (mem_req),
      .i_ld_req  (ld_req),
      .o_owner   (w_pick_owner),
      .o_valid   (w_pick_valid)
   );

   // Byte offset and bits above the RAM index are deliberately dropped (truncate / wrap).
   assign w_unused = ^{if_addr[ADDR_W-1:RAM_ADDR_W+2], if_addr[1:0],
                       mem_addr[ADDR_W-1:RAM_ADDR_W+2], mem_addr[1:0],
                       ld_addr[ADDR_W-1:RAM_ADDR_W+2], ld_addr[1:0]};

   // Route the winning requester's operands toward the RAM port.
   always_comb begin
      w_sel_idx   = if_addr[RAM_ADDR_W+1:2];
      w_sel_wdata = {DATA_W{1'b0}};
      w_sel_we    = 1'b0;
      case (w_pick_owner)
         OWN_LD: begin
            w_sel_idx   = ld_addr[RAM_ADDR_W+1:2];
            w_sel_wdata = ld_wdata;
            w_sel_we    = 1'b1;
         end
         OWN_MEM: begin
            w_sel_idx   = mem_addr[RAM_ADDR_W+1:2];
            w_sel_wdata = mem_wdata;
            w_sel_we    = mem_we;
         end
         OWN_IF: begin
            w_sel_idx   = if_addr[RAM_ADDR_W+1:2];
            w_sel_wdata = {DATA_W{1'b0}};
            w_sel_we    = 1'b0;
         end
         default: begin
            w_sel_idx   = if_addr[RAM_ADDR_W+1:2];
            w_sel_wdata = {DATA_W{1'b0}};
            w_sel_we    = 1'b0;
         end
      endcase
   end

   // Read data is valid in the last WAIT cycle; DONE follows a write's ISSUE or that capture.
   always_comb begin
      w_capture    = (r_state == ST_WAIT) && (r_cnt == 4'd0);
      w_enter_done = w_capture || ((r_state == ST_ISSUE) && r_we);
   end

   // Transaction FSM; the RAM port registers load at the grant edge so they are valid in ISSUE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_NONE;
         r_we        <= 1'b0;
         r_cnt       <= 4'd0;
         r_ram_addr  <= {RAM_ADDR_W{1'b0}};
         r_ram_wdata <= {DATA_W{1'b0}};
         r_ram_we    <= 1'b0;
      end else begin
         r_ram_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_state    <= ST_ISSUE;
                  r_owner    <= w_pick_owner;
                  r_we       <= w_sel_we;
                  r_ram_addr <= w_sel_idx;
                  r_ram_we   <= w_sel_we;
                  if (w_sel_we) begin
                     r_ram_wdata <= w_sel_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               if (r_we) begin
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_WAIT;
                  r_cnt   <= LP_CNT_INIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_owner <= OWN_NONE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_owner <= OWN_NONE;
            end
         endcase
      end
   end

   // Per-requester ack pulse for the DONE cycle and read-data capture for the reading owner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_if_ack    <= 1'b0;
         r_mem_ack   <= 1'b0;
         r_ld_ack    <= 1'b0;
         r_if_rdata  <= {DATA_W{1'b0}};
         r_mem_rdata <= {DATA_W{1'b0}};
      end else begin
         r_if_ack  <= w_enter_done && (r_owner == OWN_IF);
         r_mem_ack <= w_enter_done && (r_owner == OWN_MEM);
         r_ld_ack  <= w_enter_done && (r_owner == OWN_LD);
         if (w_capture && (r_owner == OWN_IF)) begin
            r_if_rdata <= ram_rdata;
         end
         if (w_capture && (r_owner == OWN_MEM)) begin
            r_mem_rdata <= ram_rdata;
         end
      end
   end

   assign owner     = r_owner;
   assign busy      = (r_state != ST_IDLE);
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign ram_we    = r_ram_we;
   assign if_rdata  = r_if_rdata;
   assign mem_rdata = r_mem_rdata;
   assign if_ack    = r_if_ack;
   assign mem_ack   = r_mem_ack;
   assign ld_ack    = r_ld_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, hand sequences and random traffic
// checked against a word-array reference model of the RAM contents and handshake timing.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, mem_req, mem_we, ld_req;
   logic [31:0] if_addr, mem_addr, mem_wdata, ld_addr, ld_wdata;
   logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
   logic        if_ack, mem_ack, ld_ack, ram_we, busy;
   logic [13:0] ram_addr;
   logic [1:0]  owner;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_ADDR_W(14), .RAM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .owner(owner), .busy(busy)
   );

   // Synchronous RAM macro: data for an address cycle appears LAT cycles later.
   logic [31:0] ram  [0:16383];
   logic [31:0] pipe [0:LAT-1];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      pipe[0] <= ram[ram_addr];
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
   end
   assign ram_rdata = pipe[LAT-1];

   // Reference model state
   bit   [31:0] ref_mem [0:16383];
   logic [31:0] exp_if_rd, exp_mem_rd;
   int          n_chk, n_pass;

   typedef struct {
      logic [2:0]  reqs;       // {ld, mem, if}
      logic        mwe;
      logic [31:0] ia, ma, mw, la, lw;
      logic        hold;
      logic [1:0]  exp_owner;
      logic [13:0] exp_idx;
   } txn_t;
   txn_t tbl [0:9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   // One arbitrated transaction, starting #1 after an edge with the DUT in IDLE.
   task automatic run_txn(input logic [2:0] reqs, input logic mwe, input logic [31:0] ia,
                          input logic [31:0] ma, input logic [31:0] mw, input logic [31:0] la,
                          input logic [31:0] lw, input logic hold, input logic [1:0] exp_owner,
                          input logic [13:0] exp_idx);
      logic        is_wr, got;
      logic [31:0] wd;
      logic [2:0]  exp_ack;
      int          lat, c, we_cnt;
      is_wr   = (exp_owner == 2'd3) || ((exp_owner == 2'd2) && mwe);
      wd      = (exp_owner == 2'd3) ? lw : mw;
      lat     = is_wr ? 2 : LAT + 2;
      exp_ack = 3'b001 << (exp_owner - 2'd1);
      if_req = reqs[0]; mem_req = reqs[1]; ld_req = reqs[2];
      if_addr = ia; mem_addr = ma; mem_we = mwe; mem_wdata = mw; ld_addr = la; ld_wdata = lw;
      @(posedge clk); #1;
      chk("owner_grant", {30'd0, owner}, {30'd0, exp_owner});
      chk("busy_grant", {31'd0, busy}, 32'd1);
      chk("ram_addr_issue", {18'd0, ram_addr}, {18'd0, exp_idx});
      chk("ram_we_issue", {31'd0, ram_we}, {31'd0, is_wr});
      if (is_wr) chk("ram_wdata_issue", ram_wdata, wd);
      we_cnt = int'(ram_we);
      if (exp_owner != 2'd1) if_req = 1'b0;
      if (exp_owner != 2'd2) mem_req = 1'b0;
      if (exp_owner != 2'd3) ld_req = 1'b0;
      if (!hold) begin if_req = 1'b0; mem_req = 1'b0; ld_req = 1'b0; end
      got = 1'b0;
      c = 1;
      while (!got && c < 40) begin
         @(posedge clk); #1;
         c++;
         we_cnt += int'(ram_we);
         if ({ld_ack, mem_ack, if_ack} != 3'b000) got = 1'b1;
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
      chk("ack_who", {29'd0, ld_ack, mem_ack, if_ack}, {29'd0, exp_ack});
      chk("ack_latency", c, lat);
      if (is_wr) ref_mem[exp_idx] = wd;
      else if (exp_owner == 2'd1) exp_if_rd = ref_mem[exp_idx];
      else exp_mem_rd = ref_mem[exp_idx];
      chk("if_rdata", if_rdata, exp_if_rd);
      chk("mem_rdata", mem_rdata, exp_mem_rd);
      chk("ram_we_pulses", we_cnt, {31'd0, is_wr});
      if_req = 1'b0; mem_req = 1'b0; ld_req = 1'b0;
      @(posedge clk); #1;
      chk("owner_idle", {30'd0, owner}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("acks_idle", {29'd0, ld_ack, mem_ack, if_ack}, 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_owner"}, {30'd0, owner}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_acks"}, {29'd0, ld_ack, mem_ack, if_ack}, 32'd0);
      chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
      chk({tag, "_ram_addr"}, {18'd0, ram_addr}, 32'd0);
      chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
      chk({tag, "_if_rdata"}, if_rdata, 32'd0);
      chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
   endtask

   function automatic logic [13:0] word_idx(input logic [31:0] a);
      return 14'((a >> 2) & 32'h0000_3FFF);
   endfunction

   initial begin
      logic [1:0]  seq_own [$];
      logic [2:0]  seq_ack [$];
      logic        prev_ack;
      logic [1:0]  prev_own;
      logic [2:0]  rq, av;
      logic [31:0] ra, rm, rl, rw, rlw, a;
      logic [1:0]  w;
      n_chk = 0; n_pass = 0;
      exp_if_rd = 32'd0; exp_mem_rd = 32'd0;
      if_req = 1'b0; mem_req = 1'b0; ld_req = 1'b0; mem_we = 1'b0;
      if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0; ld_addr = 32'd0; ld_wdata = 32'd0;
      reset = 1'b1;
      #12;
      chk_all_zero("por");
      @(posedge clk); #1;
      reset = 1'b0;

      //                reqs    mwe   ia            ma            mw            la            lw            hold  own   idx
      tbl[0] = '{3'b100, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 2'd3, 14'h0004};
      tbl[1] = '{3'b001, 1'b0, 32'h0000_0010, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 2'd1, 14'h0004};
      tbl[2] = '{3'b010, 1'b1, 32'h0,        32'h0000_0020, 32'h1234_5678, 32'h0,       32'h0,        1'b1, 2'd2, 14'h0008};
      tbl[3] = '{3'b001, 1'b0, 32'h0000_0023, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 2'd1, 14'h0008};
      tbl[4] = '{3'b010, 1'b0, 32'h0,        32'hFFFF_0010, 32'h0,       32'h0,        32'h0,        1'b0, 2'd2, 14'h0004};
      tbl[5] = '{3'b100, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_FFFC, 32'hA5A5_A5A5, 1'b1, 2'd3, 14'h3FFF};
      tbl[6] = '{3'b010, 1'b0, 32'h0,        32'h0000_FFFE, 32'h0,       32'h0,        32'h0,        1'b1, 2'd2, 14'h3FFF};
      tbl[7] = '{3'b011, 1'b1, 32'h0000_0030, 32'h0000_0030, 32'h0BAD_F00D, 32'h0,     32'h0,        1'b1, 2'd2, 14'h000C};
      tbl[8] = '{3'b111, 1'b0, 32'h0000_0030, 32'h0000_0030, 32'h0,       32'h0000_0034, 32'hC0FF_EE00, 1'b1, 2'd3, 14'h000D};
      tbl[9] = '{3'b001, 1'b0, 32'h0000_0030, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 2'd1, 14'h000C};
      for (int i = 0; i < 10; i++)
         run_txn(tbl[i].reqs, tbl[i].mwe, tbl[i].ia, tbl[i].ma, tbl[i].mw, tbl[i].la,
                 tbl[i].lw, tbl[i].hold, tbl[i].exp_owner, tbl[i].exp_idx);

      // Reset during WAIT of an IF read: everything clears at once, no ack, then re-issue.
      if_req = 1'b1; if_addr = 32'h0000_0010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1 chk_all_zero("async_reset");
      if_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_if_rd = 32'd0; exp_mem_rd = 32'd0;
      av = 3'b000;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         av = av | {ld_ack, mem_ack, if_ack};
      end
      chk("no_ack_after_reset", {29'd0, av}, 32'd0);
      chk("if_rdata_after_reset", if_rdata, 32'd0);
      run_txn(3'b001, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'd1, 14'h0004);

      // All three requesters at once, each held until its own ack.
      ld_req = 1'b1; ld_addr = 32'h0000_0040; ld_wdata = 32'h0055_AA00;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0020;
      if_req = 1'b1; if_addr = 32'h0000_0010;
      prev_ack = 1'b0; prev_own = 2'd0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         if (prev_ack) chk("idle_gap_owner", {30'd0, owner}, 32'd0);
         if (owner != 2'd0 && prev_own == 2'd0) seq_own.push_back(owner);
         prev_own = owner;
         av = {ld_ack, mem_ack, if_ack};
         prev_ack = (av != 3'b000);
         if (prev_ack) begin
            seq_ack.push_back(av);
            if (av[2]) ld_req = 1'b0;
            if (av[1]) mem_req = 1'b0;
            if (av[0]) if_req = 1'b0;
         end
      end
      ref_mem[16] = 32'h0055_AA00;
      exp_mem_rd = ref_mem[8];
      exp_if_rd = ref_mem[4];
      chk("multi_grants", seq_own.size(), 3);
      chk("multi_acks", seq_ack.size(), 3);
      if (seq_own.size() == 3) begin
         chk("multi_own0", {30'd0, seq_own[0]}, 32'd3);
         chk("multi_own1", {30'd0, seq_own[1]}, 32'd2);
         chk("multi_own2", {30'd0, seq_own[2]}, 32'd1);
      end
      if (seq_ack.size() == 3) begin
         chk("multi_ack0", {29'd0, seq_ack[0]}, 32'd4);
         chk("multi_ack1", {29'd0, seq_ack[1]}, 32'd2);
         chk("multi_ack2", {29'd0, seq_ack[2]}, 32'd1);
      end
      chk("multi_mem_rdata", mem_rdata, exp_mem_rd);
      chk("multi_if_rdata", if_rdata, exp_if_rd);
      run_txn(3'b001, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'd1, 14'h0010);

      // Random traffic on words 0..15; preload them first through the loader.
      for (int k = 0; k < 16; k++) begin
         a = ($urandom & 32'hFFFF_0003) | (32'(k) << 2);
         run_txn(3'b100, 1'b0, 32'h0, 32'h0, 32'h0, a, $urandom, 1'($urandom_range(0, 1)),
                 2'd3, word_idx(a));
      end
      for (int k = 0; k < 60; k++) begin
         rq  = 3'($urandom_range(1, 7));
         ra  = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
         rm  = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
         rl  = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
         rw  = $urandom;
         rlw = $urandom;
         w   = rq[2] ? 2'd3 : (rq[1] ? 2'd2 : 2'd1);
         a   = (w == 2'd3) ? rl : ((w == 2'd2) ? rm : ra);
         run_txn(rq, 1'($urandom_range(0, 1)), ra, rm, rw, rl, rlw, 1'($urandom_range(0, 1)),
                 w, word_idx(a));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
